// File: rtl/lc3b_types.sv
// Shared LC3b types: datapath words, write masks, cache-line pieces and the
// memory arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_block;
  typedef logic [11:0]  lc3b_line_tag;
  typedef logic [2:0]   lc3b_word_offset;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FILL,
    ARB_WBACK,
    ARB_RESP
  } lc3b_arb_state;

  localparam int LINE_WORDS = 8;

  function automatic lc3b_word line_addr(input lc3b_line_tag tag);
    return {tag, 4'h0};
  endfunction

endpackage

// File: rtl/line_word_merge.sv
// Combinational byte-masked merge of one 16-bit word into a 128-bit line.
module line_word_merge
  import lc3b_types::*;
(
  input  lc3b_block       line,
  input  lc3b_word_offset offset,
  input  lc3b_word        wdata,
  input  lc3b_mem_wmask   mask,
  output lc3b_block       merged
);

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic w_sel;
      assign w_sel = (offset == 3'(gi));
      assign merged[16*gi +: 8]   = (w_sel && mask[0]) ? wdata[7:0]  : line[16*gi +: 8];
      assign merged[16*gi+8 +: 8] = (w_sel && mask[1]) ? wdata[15:8] : line[16*gi+8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a 128-bit line memory with a single
// write-through line buffer; word writes are merged by read-modify-write.
module lc3b_mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_addr1,
  input  logic          mem_read1,
  output logic [15:0]   mem_rdata1,
  output logic          mem_resp1,
  input  logic [15:0]   mem_addr2,
  input  logic          mem_read2,
  input  logic          mem_write2,
  input  logic [1:0]    mem_byte_enable2,
  input  logic [15:0]   mem_wdata2,
  output logic [15:0]   mem_rdata2,
  output logic          mem_resp2,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  lc3b_arb_state   r_state, w_state_next;
  lc3b_block       r_line;
  lc3b_line_tag    r_tag;
  logic            r_valid;
  logic            r_last2;
  logic            r_grant2;
  logic            r_is_write;
  lc3b_line_tag    r_req_tag;
  lc3b_word_offset r_req_off;
  lc3b_word        r_wdata;
  lc3b_mem_wmask   r_mask;
  lc3b_word        r_pmem_address;
  lc3b_block       r_pmem_wdata;
  lc3b_word        r_rdata1, r_rdata2;

  logic            w_req1, w_req2, w_pick2, w_req_write, w_hit;
  lc3b_line_tag    w_req_tag;
  lc3b_word_offset w_req_off;
  lc3b_block       w_merge_line, w_merged, w_src_line;
  lc3b_word_offset w_merge_off, w_src_off;
  lc3b_word        w_merge_wdata, w_word;
  lc3b_mem_wmask   w_merge_mask;
  logic            w_unused;

  assign w_unused = &{1'b0, mem_addr1[0], mem_addr2[0]};

  // On a tie the port that was not served last wins.
  assign w_req1      = mem_read1;
  assign w_req2      = mem_read2 | mem_write2;
  assign w_pick2     = w_req2 && (!w_req1 || !r_last2);
  assign w_req_tag   = w_pick2 ? mem_addr2[15:4] : mem_addr1[15:4];
  assign w_req_off   = w_pick2 ? mem_addr2[3:1]  : mem_addr1[3:1];
  assign w_req_write = w_pick2 && mem_write2;
  assign w_hit       = r_valid && (r_tag == w_req_tag);

  // IDLE merges live port-2 data into the buffer; FILL merges latched data into the fetched line.
  always_comb begin
    w_merge_line  = r_line;
    w_merge_off   = mem_addr2[3:1];
    w_merge_wdata = mem_wdata2;
    w_merge_mask  = mem_byte_enable2;
    if (r_state != ARB_IDLE) begin
      w_merge_line  = pmem_rdata;
      w_merge_off   = r_req_off;
      w_merge_wdata = r_wdata;
      w_merge_mask  = r_mask;
    end
  end

  line_word_merge u_merge (
    .line   (w_merge_line),
    .offset (w_merge_off),
    .wdata  (w_merge_wdata),
    .mask   (w_merge_mask),
    .merged (w_merged)
  );

  assign w_src_line = (r_state == ARB_FILL) ? pmem_rdata : r_line;
  assign w_src_off  = (r_state == ARB_IDLE) ? w_req_off  : r_req_off;
  assign w_word     = w_src_line[{w_src_off, 4'h0} +: 16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    mem_resp1    = 1'b0;
    mem_resp2    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_req1 || w_req2) begin
          if (!w_hit)           w_state_next = ARB_FILL;
          else if (w_req_write) w_state_next = ARB_WBACK;
          else                  w_state_next = ARB_RESP;
        end
      end
      ARB_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_state_next = r_is_write ? ARB_WBACK : ARB_RESP;
      end
      ARB_WBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) w_state_next = ARB_RESP;
      end
      ARB_RESP: begin
        mem_resp1    = !r_grant2;
        mem_resp2    = r_grant2;
        w_state_next = ARB_IDLE;
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line         <= '0;
      r_tag          <= '0;
      r_valid        <= 1'b0;
      r_last2        <= 1'b0;
      r_grant2       <= 1'b0;
      r_is_write     <= 1'b0;
      r_req_tag      <= '0;
      r_req_off      <= '0;
      r_wdata        <= '0;
      r_mask         <= '0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_rdata1       <= '0;
      r_rdata2       <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req1 || w_req2) begin
            r_grant2       <= w_pick2;
            r_is_write     <= w_req_write;
            r_req_tag      <= w_req_tag;
            r_req_off      <= w_req_off;
            r_wdata        <= mem_wdata2;
            r_mask         <= mem_byte_enable2;
            r_pmem_address <= line_addr(w_req_tag);
            if (w_hit && w_req_write) begin
              r_line       <= w_merged;
              r_pmem_wdata <= w_merged;
            end else if (w_hit && w_pick2) begin
              r_rdata2 <= w_word;
            end else if (w_hit) begin
              r_rdata1 <= w_word;
            end
          end
        end
        ARB_FILL: begin
          if (pmem_resp) begin
            r_valid <= 1'b1;
            r_tag   <= r_req_tag;
            if (r_is_write) begin
              r_line       <= w_merged;
              r_pmem_wdata <= w_merged;
            end else begin
              r_line <= pmem_rdata;
              if (r_grant2) r_rdata2 <= w_word;
              else          r_rdata1 <= w_word;
            end
          end
        end
        ARB_RESP: r_last2 <= r_grant2;
        default: ;
      endcase
    end
  end

  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign mem_rdata1   = r_rdata1;
  assign mem_rdata2   = r_rdata2;

endmodule
